// File: rtl/pwm_fade_sequencer.sv
// PWM duty fade sequencer: ramps duty_out toward a commanded target,
// one step per PWM period, updating only on period boundaries.
module pwm_fade_sequencer #(
  parameter int DUTY_W = 6,
  parameter int PERIOD = 32,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_target,
  input  logic [STEP_W-1:0] cmd_step,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty_out,
  output logic              period_start,
  output logic              busy,
  output logic              done
);

  localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  typedef enum logic {IDLE, RAMP} state_t;

  state_t            state;
  logic [PW-1:0]     pcnt;
  logic [DUTY_W-1:0] target;
  logic [STEP_W-1:0] step;
  logic              boundary;
  logic [DUTY_W:0]   duty_x;
  logic [DUTY_W:0]   tgt_x;
  logic [DUTY_W:0]   step_x;
  logic [DUTY_W:0]   up_sum;
  logic [DUTY_W:0]   dn_gap;
  logic [DUTY_W:0]   next_duty;

  assign boundary     = (pcnt == PW'(PERIOD - 1));
  assign period_start = (pcnt == '0);
  assign cmd_ready    = (state == IDLE);
  assign busy         = (state == RAMP);

  // One extra bit of headroom so the clamp compares never wrap
  always_comb begin
    duty_x    = {1'b0, duty_out};
    tgt_x     = {1'b0, target};
    step_x    = (DUTY_W + 1)'(step);
    up_sum    = duty_x + step_x;
    dn_gap    = duty_x - tgt_x;
    next_duty = duty_x;
    if (duty_x < tgt_x) begin
      next_duty = (up_sum > tgt_x) ? tgt_x : up_sum;
    end else if (duty_x > tgt_x) begin
      next_duty = (dn_gap <= step_x) ? tgt_x : duty_x - step_x;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt     <= '0;
      state    <= IDLE;
      duty_out <= '0;
      done     <= 1'b0;
      target   <= '0;
      step     <= '0;
    end else begin
      pcnt <= boundary ? '0 : pcnt + PW'(1);
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            target <= cmd_target;
            step   <= (cmd_step == '0) ? STEP_W'(1) : cmd_step;
            state  <= RAMP;
          end
        end
        RAMP: begin
          if (abort) begin
            state <= IDLE;
          end else if (boundary) begin
            duty_out <= next_duty[DUTY_W-1:0];
            if (next_duty[DUTY_W-1:0] == target) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Scoreboard bench for pwm_fade_sequencer: ramp trajectories are
// computed up front and checked by an independent output monitor.
module tb_pwm_fade_sequencer;

  localparam int P = 32;

  typedef struct {
    int cyc;
    int duty;
    bit fin;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [5:0] cmd_target = '0;
  logic [2:0] cmd_step = '0;
  logic       abort = 1'b0;
  logic [5:0] duty_out;
  logic       period_start;
  logic       busy;
  logic       done;

  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   mpcnt = 0;
  int   mduty = 0;
  exp_t q[$];

  pwm_fade_sequencer #(.DUTY_W(6), .PERIOD(P), .STEP_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_target(cmd_target),
    .cmd_step(cmd_step),
    .abort(abort),
    .duty_out(duty_out),
    .period_start(period_start),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) mpcnt <= 0;
    else mpcnt <= (mpcnt == P - 1) ? 0 : mpcnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: any duty change or done pulse is an output event
  initial begin : monitor
    int   prev;
    exp_t e;
    prev = 0;
    forever begin
      @(posedge clk);
      #2;
      check("period_start", 32'(period_start), 32'(mpcnt == 0));
      if (rst) begin
        prev = int'(duty_out);
      end else if ((int'(duty_out) != prev) || done) begin
        if (q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_output: duty_out=%0d done=%0d at cycle %0d, none expected",
                   duty_out, done, cyc);
        end else begin
          e = q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("duty", 32'(duty_out), e.duty);
          check("done", 32'(done), 32'(e.fin));
          if (e.fin) begin
            check("ready_on_done", 32'(cmd_ready), 1);
            check("busy_on_done", 32'(busy), 0);
          end else begin
            check("busy_in_ramp", 32'(busy), 1);
          end
        end
        prev = int'(duty_out);
      end
    end
  end

  // Called and returns at a negedge. keep<0 pushes the whole ramp.
  task automatic run_cmd(input int tgt, input int stp, input int keep,
                         input bit hold, input int other);
    int c, p, s, d, cur, last, k, mafter;
    bit fin;
    c = cyc;
    p = mpcnt;
    check("ready_before_cmd", 32'(cmd_ready), 1);
    cmd_valid  = 1'b1;
    cmd_target = 6'(tgt);
    cmd_step   = 3'(stp);
    s = (stp == 0) ? 1 : stp;
    d = (p == P - 1) ? P : (P - 1 - p);
    cur = mduty;
    mafter = mduty;
    last = c;
    k = 0;
    fin = 1'b0;
    while (!fin) begin
      if (cur < tgt) cur = (cur + s > tgt) ? tgt : cur + s;
      else if (cur > tgt) cur = (cur - s < tgt) ? tgt : cur - s;
      fin = (cur == tgt);
      if (keep < 0 || k < keep) begin
        last = c + 1 + d + k * P;
        q.push_back('{last, cur, fin});
        mafter = cur;
      end
      k++;
    end
    @(negedge clk);
    if (hold) cmd_target = 6'(other);
    else cmd_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 1);
    check("ready_after_accept", 32'(cmd_ready), 0);
    while (cyc < last) @(negedge clk);
    mduty = mafter;
  endtask

  task automatic check_idle(input string name, input int duty);
    check({name, "_duty"}, 32'(duty_out), duty);
    check({name, "_ready"}, 32'(cmd_ready), 1);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_done"}, 32'(done), 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      check_idle("reset_idle", 0);
      @(negedge clk);
    end

    run_cmd(20, 4, -1, 1'b0, 0);
    run_cmd(3, 5, -1, 1'b0, 0);
    run_cmd(60, 7, -1, 1'b0, 0);
    run_cmd(63, 0, -1, 1'b0, 0);
    run_cmd(60, 3, -1, 1'b0, 0);
    run_cmd(63, 7, -1, 1'b0, 0);
    repeat (5) @(negedge clk);

    run_cmd(0, 7, -1, 1'b0, 0);
    run_cmd(40, 2, 5, 1'b0, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort_mid", 10);
    repeat (2 * P) @(negedge clk);

    run_cmd(40, 2, 0, 1'b0, 0);
    while (mpcnt != P - 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort_boundary", 10);
    repeat (2 * P) @(negedge clk);

    run_cmd(30, 3, -1, 1'b1, 50);
    run_cmd(50, 5, -1, 1'b0, 0);
    run_cmd(50, 4, -1, 1'b0, 0);
    repeat (3) @(negedge clk);

    run_cmd(20, 1, 2, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    check_idle("reset_mid", 0);
    q.delete();
    mduty = 0;
    rst = 1'b0;
    repeat (P + 7) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      run_cmd(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
              -1, 1'b0, 0);
    end

    repeat (2 * P) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
